// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the iterative restoring divider feeding the hi/lo register file.
// Optional DIV_FAST_PATH_EN: operations with |a| < |b| finish in one cycle.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  input  logic               annul_i,
  output logic               stallreq_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               hi_we_o,
  output logic               lo_we_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_ZERO = 2'd1,
    S_DIV_ON   = 2'd2,
    S_DIV_END  = 2'd3
  } state_e;

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [WIDTH:0]     part_s;
  logic               ge_s;
  logic [WIDTH-1:0]   diff_s, rem_nxt_s, quo_nxt_s, quo_fix_s, rem_fix_s;

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  assign abs_a_s = neg_if(signed_i & op_a_i[WIDTH-1], op_a_i);
  assign abs_b_s = neg_if(signed_i & op_b_i[WIDTH-1], op_b_i);

  // Partial remainder is one bit wider so divisors with the MSB set compare correctly.
  assign part_s    = {rem_q, dvd_q[WIDTH-1]};
  assign ge_s      = (part_s >= {1'b0, dvs_q});
  assign diff_s    = part_s[WIDTH-1:0] - dvs_q;
  assign rem_nxt_s = ge_s ? diff_s : part_s[WIDTH-1:0];
  assign quo_nxt_s = {dvd_q[WIDTH-2:0], ge_s};
  assign quo_fix_s = neg_if(sgn_q & (a_neg_q ^ b_neg_q), quo_nxt_s);
  assign rem_fix_s = neg_if(sgn_q & a_neg_q, rem_nxt_s);

  assign stallreq_o = start_i & ~ready_q & ~annul_i & ~rst;
  assign ready_o    = ready_q;
  assign hi_we_o    = ready_q;
  assign lo_we_o    = ready_q;
  assign result_o   = result_q;

  // Next-state and datapath update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    op_a_d   = op_a_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_IDLE: begin
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
        if (start_i && !annul_i) begin
          sgn_d   = signed_i;
          a_neg_d = signed_i & op_a_i[WIDTH-1];
          b_neg_d = signed_i & op_b_i[WIDTH-1];
          op_a_d  = op_a_i;
          dvd_d   = abs_a_s;
          dvs_d   = abs_b_s;
          rem_d   = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          if (op_b_i == {WIDTH{1'b0}}) begin
            state_d = S_DIV_ZERO;
          end
`ifdef DIV_FAST_PATH_EN
          else if (abs_a_s < abs_b_s) begin
            state_d  = S_DIV_END;
            ready_d  = 1'b1;
            result_d = {op_a_i, {WIDTH{1'b0}}};
          end
`endif
          else begin
            state_d = S_DIV_ON;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV_ZERO: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DIV_END;
          ready_d  = 1'b1;
          result_d = {op_a_q, {WIDTH{1'b1}}};
        end
      end
      S_DIV_ON: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nxt_s;
          dvd_d = quo_nxt_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = S_DIV_END;
            ready_d  = 1'b1;
            result_d = {rem_fix_s, quo_fix_s};
          end else begin
            state_d = S_DIV_ON;
          end
        end
      end
      S_DIV_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          state_d = S_DIV_END;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      sgn_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      op_a_q   <= {WIDTH{1'b0}};
      dvd_q    <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      result_q <= {(2*WIDTH){1'b0}};
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      op_a_q   <= op_a_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized self-checking bench for div_seq_ctrl against an arithmetic reference model.
module tb_div_seq_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, signed_i, annul_i;
  logic [W-1:0]  op_a_i, op_b_i;
  logic          stallreq_o, ready_o, hi_we_o, lo_we_o;
  logic [2*W-1:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .op_a_i    (op_a_i),
    .op_b_i    (op_b_i),
    .annul_i   (annul_i),
    .stallreq_o(stallreq_o),
    .ready_o   (ready_o),
    .result_o  (result_o),
    .hi_we_o   (hi_we_o),
    .lo_we_o   (lo_we_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint to_int(input logic [31:0] v, input logic sgn);
    if (sgn) return longint'($signed(v));
    return longint'({32'd0, v});
  endfunction

  // {hi, lo} = {remainder, quotient}, truncating division as the ISA defines it.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = to_int(a, sgn);
    sb = to_int(b, sgn);
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb;
    sa = to_int(a, sgn);
    sb = to_int(b, sgn);
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (b == 32'd0) return 2;
`ifdef DIV_FAST_PATH_EN
    if (sa < sb) return 1;
`endif
    return W + 1;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] exp;
    int lat, k;
    bit stall_ok;
    exp = ref_div(a, b, sgn);
    lat = ref_lat(a, b, sgn);
    start_i = 1'b1; signed_i = sgn; op_a_i = a; op_b_i = b;
    #1;
    stall_ok = (stallreq_o === 1'b1) && (ready_o === 1'b0);
    k = 0;
    while (ready_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      op_a_i = $urandom; op_b_i = $urandom; signed_i = 1'($urandom);
      if (ready_o !== 1'b1 && stallreq_o !== 1'b1) stall_ok = 1'b0;
    end
    check_eq("latency", 64'(k), 64'(lat));
    check_eq("result", result_o, exp);
    check_eq("we", {62'd0, hi_we_o, lo_we_o}, 64'd3);
    check_eq("stall", {63'd0, stall_ok}, 64'd1);
    @(negedge clk);
    check_eq("hold", {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    start_i = 1'b0;
    @(negedge clk);
    check_eq("idle", {ready_o, result_o[62:0]}, 64'd0);
  endtask

  task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int at, input bit use_annul);
    bit quiet;
    start_i = 1'b1; signed_i = sgn; op_a_i = a; op_b_i = b;
    for (int i = 0; i < at; i++) @(negedge clk);
    if (use_annul) begin
      annul_i = 1'b1;
      #1;
      check_eq("annul_stall", {63'd0, stallreq_o}, 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
    end
    start_i = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) quiet = 1'b0;
    end
    check_eq("abort_quiet", {63'd0, quiet}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    op_a_i = 32'd0; op_b_i = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("reset", {ready_o, hi_we_o, lo_we_o, stallreq_o, result_o[59:0]}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'hFFFF_FFFD, 32'd0, 1'b1);
    run_op(32'd3, 32'd10, 1'b0);
    run_op(32'hFFFF_FFFD, 32'd10, 1'b1);
    run_op(32'd0, 32'd5, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);

    abort_op(32'd1000, 32'd3, 1'b1, 10, 1'b1);
    run_op(32'd9, 32'd3, 1'b0);
    abort_op(32'd77, 32'd5, 1'b0, 0, 1'b1);
    abort_op(32'd77, 32'd5, 1'b0, 7, 1'b0);
    abort_op(32'd77, 32'd0, 1'b0, 1, 1'b0);
    abort_op(32'd77, 32'd5, 1'b0, W + 1, 1'b1);

    // Asynchronous reset in the middle of an operation.
    start_i = 1'b1; signed_i = 1'b0; op_a_i = 32'd1000; op_b_i = 32'd3;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst", {61'd0, ready_o, stallreq_o, |result_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    run_op(32'd1000, 32'd3, 1'b1);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(1, 15);
        1:       rb = $urandom;
        2:       rb = ra + 32'($urandom_range(0, 4));
        default: rb = 32'd0;
      endcase
      run_op(ra, rb, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
